// File: rtl/lcd_bus_sequencer_if.sv
// Signal bundle between the LCD output register / input-buffer side and the HD44780-style bus
// sequencer. The slave modport is the sequencer's view.
interface lcd_bus_sequencer_if;
  logic [31:0] i_io_lcd;
  logic [7:0]  i_lcd_data;
  logic        o_lcd_on;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic        o_lcd_en;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_data_oe;
  logic [7:0]  o_rd_data;
  logic        o_busy;
  logic        o_done;
  logic        o_overrun;

  modport slave (
    input  i_io_lcd, i_lcd_data,
    output o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_data, o_lcd_data_oe,
           o_rd_data, o_busy, o_done, o_overrun
  );

  modport master (
    output i_io_lcd, i_lcd_data,
    input  o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_data, o_lcd_data_oe,
           o_rd_data, o_busy, o_done, o_overrun
  );
endinterface

// File: rtl/lcd_bus_sequencer.sv
// Turns writes to the LCD register into timed HD44780 bus cycles with a one-deep pending slot.
// Define LCD_BUSY_POLL_EN to replace the fixed execution wait with a busy-flag poll loop.
module lcd_bus_sequencer #(
  parameter int unsigned T_SETUP_CYC = 4,
  parameter int unsigned T_PW_CYC    = 25,
  parameter int unsigned T_HOLD_CYC  = 2,
  parameter int unsigned T_EXEC_CYC  = 2500,
  parameter int unsigned T_CLR_CYC   = 82000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  lcd_bus_sequencer_if.slave bus
);

  localparam int unsigned CntW = $clog2(T_CLR_CYC + 1);
  localparam logic [CntW-1:0] LdSetup = CntW'(T_SETUP_CYC - 1);
  localparam logic [CntW-1:0] LdPw    = CntW'(T_PW_CYC - 1);
  localparam logic [CntW-1:0] LdHold  = CntW'(T_HOLD_CYC - 1);
  localparam logic [CntW-1:0] LdExec  = CntW'(T_EXEC_CYC - 1);
  localparam logic [CntW-1:0] LdClr   = CntW'(T_CLR_CYC - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StPulse, StHold, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            start_q, on_q;
  logic            rs_q, rs_d, rw_q, rw_d;
  logic [7:0]      data_q, data_d, rd_data_q, rd_data_d;
  logic            pend_vld_q, pend_vld_d;
  logic [9:0]      pend_q, pend_d;
  logic            overrun_q, overrun_d;
  logic            req, last;
`ifdef LCD_BUSY_POLL_EN
  logic            poll_q, poll_d, db7_q, db7_d;
  logic [CntW-1:0] tmo_q, tmo_d;
`else
  logic            is_clr;
`endif
  logic            unused_io;

  assign unused_io = ^bus.i_io_lcd[30:11];
  assign req       = bus.i_io_lcd[10] & ~start_q;
  assign last      = (cnt_q == '0);
`ifndef LCD_BUSY_POLL_EN
  assign is_clr    = ~rs_q & ~rw_q & (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = last ? cnt_q : cnt_q - 1'b1;
    rs_d       = rs_q;
    rw_d       = rw_q;
    data_d     = data_q;
    rd_data_d  = rd_data_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    overrun_d  = overrun_q;
`ifdef LCD_BUSY_POLL_EN
    poll_d     = poll_q;
    db7_d      = db7_q;
    tmo_d      = tmo_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (pend_vld_q) begin
          {rs_d, rw_d, data_d} = pend_q;
          pend_vld_d           = 1'b0;
          state_d              = StSetup;
        end else if (req) begin
          {rs_d, rw_d, data_d} = bus.i_io_lcd[9:0];
          state_d              = StSetup;
        end
      end
      StSetup: if (last) state_d = StPulse;
      StPulse: begin
        if (last) begin
          state_d = StHold;
`ifdef LCD_BUSY_POLL_EN
          if (poll_q)    db7_d     = bus.i_lcd_data[7];
          else if (rw_q) rd_data_d = bus.i_lcd_data;
`else
          if (rw_q) rd_data_d = bus.i_lcd_data;
`endif
        end
      end
      StHold: begin
        if (last) begin
`ifdef LCD_BUSY_POLL_EN
          if (poll_q) begin
            if (!db7_q) begin
              state_d = StDone;
              poll_d  = 1'b0;
            end else begin
              state_d = StSetup;
            end
          end else if (!rs_q && rw_q) begin
            state_d = StDone;
          end else begin
            // Start the poll loop as an internal busy-flag read.
            poll_d  = 1'b1;
            rs_d    = 1'b0;
            rw_d    = 1'b1;
            tmo_d   = LdClr;
            state_d = StSetup;
          end
`else
          state_d = (!rs_q && rw_q) ? StDone : StWait;
`endif
        end
      end
      StWait: if (last) state_d = StDone;
      StDone: begin
        if (pend_vld_q) begin
          {rs_d, rw_d, data_d} = pend_q;
          pend_vld_d           = 1'b0;
          state_d              = StSetup;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef LCD_BUSY_POLL_EN
    if (poll_q) begin
      if (tmo_q == '0) begin
        state_d = StDone;
        poll_d  = 1'b0;
      end else begin
        tmo_d = tmo_q - 1'b1;
      end
    end
`endif

    // A request not consumed directly from IDLE goes to the slot, which frees up in IDLE/DONE.
    if (req && !(state_q == StIdle && !pend_vld_q)) begin
      if (!pend_vld_q || state_q == StIdle || state_q == StDone) begin
        pend_d     = bus.i_io_lcd[9:0];
        pend_vld_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (state_d != state_q) begin
      unique case (state_d)
        StSetup: cnt_d = LdSetup;
        StPulse: cnt_d = LdPw;
        StHold:  cnt_d = LdHold;
`ifdef LCD_BUSY_POLL_EN
        StWait:  cnt_d = LdExec;
`else
        StWait:  cnt_d = is_clr ? LdClr : LdExec;
`endif
        default: cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      on_q       <= 1'b0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
      data_q     <= '0;
      rd_data_q  <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      overrun_q  <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      poll_q     <= 1'b0;
      db7_q      <= 1'b0;
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      start_q    <= bus.i_io_lcd[10];
      on_q       <= bus.i_io_lcd[31];
      rs_q       <= rs_d;
      rw_q       <= rw_d;
      data_q     <= data_d;
      rd_data_q  <= rd_data_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      overrun_q  <= overrun_d;
`ifdef LCD_BUSY_POLL_EN
      poll_q     <= poll_d;
      db7_q      <= db7_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign bus.o_lcd_on      = on_q;
  assign bus.o_lcd_rs      = rs_q;
  assign bus.o_lcd_rw      = rw_q;
  assign bus.o_lcd_en      = (state_q == StPulse);
  assign bus.o_lcd_data    = data_q;
  assign bus.o_lcd_data_oe = ~rw_q &
                             (state_q == StSetup || state_q == StPulse || state_q == StHold);
  assign bus.o_rd_data     = rd_data_q;
  assign bus.o_busy        = (state_q != StIdle) | pend_vld_q;
  assign bus.o_done        = (state_q == StDone);
  assign bus.o_overrun     = overrun_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Directed bench for lcd_bus_sequencer with short timing parameters; cycle k counts posedges
// since the START write became visible to the DUT.
module tb_lcd_bus_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  lcd_bus_sequencer_if bus ();

  lcd_bus_sequencer #(
    .T_SETUP_CYC(2),
    .T_PW_CYC   (3),
    .T_HOLD_CYC (1),
    .T_EXEC_CYC (10),
    .T_CLR_CYC  (40)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one START edge and watch until one cycle past o_done (bounded).
  task automatic xfer(input logic [31:0] val, output int en_first, output int en_cnt,
                      output int oe_cnt, output int done_at);
    en_first = -1;
    en_cnt   = 0;
    oe_cnt   = 0;
    done_at  = -1;
    bus.i_io_lcd = val;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (k == 1) bus.i_io_lcd[10] = 1'b0;
      if (bus.o_lcd_en) begin
        if (en_first < 0) en_first = k;
        en_cnt++;
      end
      if (bus.o_lcd_data_oe) oe_cnt++;
      if (bus.o_done && done_at < 0) done_at = k;
      if (done_at >= 0 && k > done_at) break;
    end
  endtask

  initial begin
    int ef, ec, oc, d38, d01, n_en, n_done, n_busy;
    logic [31:0] outs;

    // Reset and idle
    bus.i_io_lcd   = 32'h0;
    bus.i_lcd_data = 8'h00;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    outs = {bus.o_lcd_on, bus.o_lcd_rs, bus.o_lcd_rw, bus.o_lcd_en, bus.o_lcd_data,
            bus.o_lcd_data_oe, bus.o_rd_data, bus.o_busy, bus.o_done, bus.o_overrun};
    chk("reset_outputs", outs, 32'h0);
    n_en = 0;
    n_busy = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (bus.o_lcd_en) n_en++;
      if (bus.o_busy) n_busy++;
    end
    chk("idle_en", n_en, 0);
    chk("idle_busy", n_busy, 0);

    // Data write RS=1 DATA=0x41
    xfer(32'h0000_0641, ef, ec, oc, d38);
    chk("wr_en_first", ef, 3);
    chk("wr_en_cnt", ec, 3);
    chk("wr_oe_cnt", oc, 6);
    chk("wr_done_at", d38, 17);
    chk("wr_busy_after", bus.o_busy, 1'b0);
    chk("wr_rs", bus.o_lcd_rs, 1'b1);
    chk("wr_data", bus.o_lcd_data, 8'h41);

    // Normal command vs clear: 30 extra wait cycles
    xfer(32'h0000_0438, ef, ec, oc, d38);
    chk("cmd38_done_at", d38, 17);
    xfer(32'h0000_0401, ef, ec, oc, d01);
    chk("clr_done_at", d01, 47);
    chk("clr_minus_cmd", d01 - d38, 30);

    // Data read RS=1 RW=1
    bus.i_lcd_data = 8'h5A;
    xfer(32'h0000_0700, ef, ec, oc, d38);
    chk("rd_oe_cnt", oc, 0);
    chk("rd_en_cnt", ec, 3);
    chk("rd_done_at", d38, 17);
    chk("rd_data", bus.o_rd_data, 8'h5A);

    // Busy-flag read skips the execution wait
    bus.i_lcd_data = 8'h80;
    xfer(32'h0000_0500, ef, ec, oc, d38);
    chk("bf_done_at", d38, 7);
    chk("bf_rd_data", bus.o_rd_data, 8'h80);
    bus.i_lcd_data = 8'h00;

    // ON passthrough
    bus.i_io_lcd = 32'h8000_0000;
    chk("on_before", bus.o_lcd_on, 1'b0);
    step();
    chk("on_set", bus.o_lcd_on, 1'b1);
    bus.i_io_lcd = 32'h0;
    step();
    chk("on_clr", bus.o_lcd_on, 1'b0);

    // Three START edges 4 cycles apart: second pends, third is dropped
    n_done = 0;
    d01 = -1;
    bus.i_io_lcd = 32'h0000_0641;
    for (int k = 1; k <= 60; k++) begin
      step();
      bus.i_io_lcd = (k == 3) ? 32'h0000_0642 : (k == 7) ? 32'h0000_0643 : 32'h0000_0240;
      if (k == 7) chk("ovr_before", bus.o_overrun, 1'b0);
      if (k == 8) chk("ovr_after", bus.o_overrun, 1'b1);
      if (k == 18) chk("second_rs_data", {bus.o_lcd_rs, bus.o_lcd_data}, 9'h142);
      if (k == 18) chk("second_busy", bus.o_busy, 1'b1);
      if (k == 35) chk("seq_idle", bus.o_busy, 1'b0);
      if (bus.o_done) begin
        n_done++;
        if (n_done == 2) d01 = k;
      end
    end
    chk("seq_done_cnt", n_done, 2);
    chk("seq_second_done", d01, 34);
    chk("ovr_sticky", bus.o_overrun, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ovr_reset", bus.o_overrun, 1'b0);

    // Reset during PULSE with a pending request
    bus.i_io_lcd = 32'h0000_0641;
    step();
    bus.i_io_lcd = 32'h0000_0241;
    step();
    bus.i_io_lcd = 32'h0000_0642;
    step();
    chk("pulse_en", bus.o_lcd_en, 1'b1);
    rst = 1'b1;
    bus.i_io_lcd = 32'h0;
    step();
    chk("rst_en", bus.o_lcd_en, 1'b0);
    chk("rst_busy", bus.o_busy, 1'b0);
    rst = 1'b0;
    n_en = 0;
    n_busy = 0;
    n_done = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (bus.o_lcd_en) n_en++;
      if (bus.o_busy) n_busy++;
      if (bus.o_done) n_done++;
    end
    chk("post_rst_en", n_en, 0);
    chk("post_rst_busy", n_busy, 0);
    chk("post_rst_done", n_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lcd_bus_sequencer.md
Name: lcd_bus_sequencer

Overview:
- Downstream consumer of the LCD output register in the LSU output buffer (the 32-bit value at 0x7030).
- Converts software writes to that register into correctly timed HD44780-style bus cycles: setup, enable pulse, hold, then an execution wait.
- Holds one pending transfer, reports busy/done/overrun status, and captures read data for a later input-buffer readback.

Parameters:
- T_SETUP_CYC, 4, RS/RW/DATA setup cycles before EN rises (>=1)
- T_PW_CYC, 25, EN high cycles (>=1)
- T_HOLD_CYC, 2, cycles after EN falls before bus release (>=1)
- T_EXEC_CYC, 2500, execution wait for normal commands/data writes (>=1)
- T_CLR_CYC, 82000, execution wait for clear/home commands (>=1)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_io_lcd  in  32  LCD register value. Fields: [31] ON, [10] START, [9] RS, [8] RW, [7:0] DATA
- i_lcd_data  in  8  data bus sampled on reads
- o_lcd_on  out  1  registered copy of i_io_lcd[31]
- o_lcd_rs  out  1  register select
- o_lcd_rw  out  1  1 = read
- o_lcd_en  out  1  enable strobe
- o_lcd_data  out  8  write data
- o_lcd_data_oe  out  1  bus drive enable
- o_rd_data  out  8  last read byte
- o_busy  out  1  transfer in progress or pending
- o_done  out  1  one-cycle pulse at transfer completion
- o_overrun  out  1  sticky: request dropped

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; pending slot empty; start-edge history register 0. A reset mid-transfer drops EN at the next edge and discards the pending slot.
- Request: a rising edge of i_io_lcd[10], registered with the history flop, captures {RS, RW, DATA}.
- FSM states and transitions:
  - IDLE: a request, or a non-empty pending slot, goes to SETUP on the next edge. The pending slot takes priority.
  - SETUP: rs/rw/data driven; o_lcd_data_oe = ~RW. Lasts T_SETUP_CYC cycles, then goes to PULSE.
  - PULSE: o_lcd_en = 1 for exactly T_PW_CYC cycles. If RW = 1, i_lcd_data is captured into o_rd_data in the last PULSE cycle. Then goes to HOLD.
  - HOLD: EN = 0; rs/rw/data held. Lasts T_HOLD_CYC cycles. On exit: o_lcd_data_oe = 0, and the FSM goes to WAIT (or straight to DONE for a busy-flag read, RS=0/RW=1).
  - WAIT: lasts T_CLR_CYC cycles when RS=0, RW=0 and DATA is in {0x01, 0x02, 0x03}; otherwise T_EXEC_CYC cycles. Then goes to DONE.
  - DONE: o_done = 1 for 1 cycle, then returns to IDLE. If the pending slot is full, goes to SETUP directly instead.
- Phase counter: one down-counter of width $clog2(T_CLR_CYC+1), loaded with (param - 1) on phase entry. Each phase lasts exactly its parameter value in cycles.
- Latency: edge seen at posedge N → SETUP from N+1 → EN rises at N+1+T_SETUP_CYC.
- o_busy: 1 whenever state ≠ IDLE or the pending slot is full.
- Request arriving while busy:
  - Pending slot empty: fields stored in the pending slot.
  - Pending slot full: request dropped and o_overrun set (sticky until reset).
- Request in the same cycle as DONE: it fills the pending slot. The previously pending request, if any, is issued first.
- ON passthrough: o_lcd_on follows i_io_lcd[31] with 1-cycle latency, independent of the FSM.
- A level held on START produces no repeated transfers; another transfer needs a new 0→1 edge.

Optional Feature:
- Macro: LCD_BUSY_POLL_EN.
- Defined: WAIT is replaced by a busy-flag poll loop. Each iteration is an internal RS=0/RW=1 bus cycle using the same SETUP/PULSE/HOLD timing. The loop exits to DONE when the sampled DB7 = 0, or when T_CLR_CYC total cycles elapse (timeout). Polled bytes do not update o_rd_data.
- Undefined: fixed WAIT as described in Behaviour; no internal read cycles are generated.

Test Plan:
Bench parameters: T_SETUP=2, T_PW=3, T_HOLD=1, T_EXEC=10, T_CLR=40.
- Reset, then i_io_lcd=0x0000_0000 → all outputs 0, o_busy=0, no EN activity over 100 cycles.
- Write i_io_lcd=0x0000_0641 (START, RS=1, RW=0, DATA=0x41) at posedge N → rs=1, data=0x41, oe=1 from N+1; EN high during N+3..N+5; oe=0 from N+7; o_done pulse at N+17; o_busy low from N+18.
- Write DATA=0x01, RS=0 → WAIT lasts 40 cycles; o_done exactly 30 cycles later than for DATA=0x38.
- Read with RS=1/RW=1 and i_lcd_data=0x5A → oe stays 0 throughout; o_rd_data=0x5A after PULSE; o_done follows T_EXEC wait.
- Three START edges while busy (toggle 0→1 every 4 cycles) → second issues immediately after the first completes; third dropped; o_overrun=1 and stays 1 until i_rst.
- i_rst asserted during PULSE → o_lcd_en=0 next cycle; o_busy=0; pending request not issued after reset release.
